gf_dec_to_pow: RTL and testbench

Converts GF(2^8) elements from the decimal (polynomial) domain to the power domain for the Reed-Solomon datapath, using primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). It is the inverse of the existing power-to-decimal lookup. After reset, the block builds its log table in RAM by stepping alpha^i through an internal multiply-by-alpha register. It then serves registered single-cycle reads. Power-domain encoding matches the forward table: value 0 is the zero element, and value p (1..255) is alpha^(p-1).

---
 rtl/gf_dec_to_pow_if.sv | 25 ++
 rtl/gf_dec_to_pow.sv | 103 ++++++++++
 tb/tb_gf_dec_to_pow.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gf_dec_to_pow_if.sv
// Read port bundle for the GF(2^8) decimal-to-power log table.
// The master issues reads; the slave returns codes and build status.
interface gf_dec_to_pow_if;
  logic       re;
  logic [7:0] address_read;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       ready;

  modport master (
    output re,
    output address_read,
    input  data_out,
    input  rd_valid,
    input  ready
  );

  modport slave (
    input  re,
    input  address_read,
    output data_out,
    output rd_valid,
    output ready
  );
endinterface

// File: rtl/gf_dec_to_pow.sv
// GF(2^8) decimal-to-power converter: builds its log table after reset
// by stepping alpha^i, then serves registered single-cycle lookups.
module gf_dec_to_pow #(
  parameter int unsigned address_width = 8,
  parameter int unsigned data_width    = 8,
  parameter logic [8:0]  prim_poly     = 9'h11D
) (
  input  logic             clk,
  input  logic             reset,
  gf_dec_to_pow_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** address_width;

  typedef enum logic [1:0] {
    S_ZERO,
    S_FILL,
    S_READY
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] elem_q, elem_d;
  logic [data_width-1:0]    cnt_q, cnt_d;
  logic [data_width-1:0]    dout_q, dout_d;
  logic                     vld_q, vld_d;
  logic                     rdy_q, rdy_d;

  logic                     we;
  logic [address_width-1:0] waddr;
  logic [data_width-1:0]    wdata;

  logic [data_width-1:0]    mem [DEPTH];

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    rdy_d   = rdy_q;
    we      = 1'b0;
    waddr   = elem_q;
    wdata   = cnt_q;
    unique case (state_q)
      S_ZERO: begin
        we      = 1'b1;
        waddr   = '0;
        wdata   = '0;
        elem_d  = address_width'(1);
        cnt_d   = data_width'(1);
        state_d = S_FILL;
      end
      S_FILL: begin
        we     = 1'b1;
        // multiply by alpha, reduced by the primitive polynomial
        elem_d = {elem_q[address_width-2:0], 1'b0}
               ^ (elem_q[address_width-1]
                  ? prim_poly[address_width-1:0]
                  : '0);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_READY;
          rdy_d   = 1'b1;
        end
      end
      S_READY: begin
        if (bus.re) begin
          dout_d = mem[bus.address_read];
          vld_d  = 1'b1;
        end
      end
      default: state_d = S_ZERO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ZERO;
      elem_q  <= address_width'(1);
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  // table storage survives reset; every rebuild overwrites all entries
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.data_out = dout_q;
  assign bus.rd_valid = vld_q;
  assign bus.ready    = rdy_q;

endmodule

// File: tb/tb_gf_dec_to_pow.sv
// Bench for gf_dec_to_pow: cycle model built from field arithmetic,
// per-cycle compare, plus directed literal checks.
module tb_gf_dec_to_pow;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gf_dec_to_pow_if bus ();

  gf_dec_to_pow #(
    .address_width (8),
    .data_width    (8),
    .prim_poly     (9'h11D)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_tab [256];
  int log_tab [256];

  int   m_edges = 0;
  logic m_ready = 1'b0;
  logic m_vld   = 1'b0;
  logic [7:0] m_dout = 8'h00;

  function automatic int gf_mul(int a, int b);
    int r = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Cycle-level expectation from the block's stated behaviour
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      m_ready = 1'b0;
      m_vld   = 1'b0;
      m_dout  = 8'h00;
    end else begin
      if (m_ready && bus.re === 1'b1) begin
        m_dout = 8'(log_tab[bus.address_read]);
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      m_edges++;
      if (m_edges == 256) m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("ready_cyc", 32'(bus.ready), 32'(m_ready));
    check("vld_cyc", 32'(bus.rd_valid), 32'(m_vld));
    check("dout_cyc", 32'(bus.data_out), 32'(m_dout));
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 32'(bus.ready), 0);
    check("async_vld", 32'(bus.rd_valid), 0);
    check("async_dout", 32'(bus.data_out), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("build_edges", n, 256);
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [7:0] d,
                    output logic v);
    bus.re = 1'b1;
    bus.address_read = a;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    d = bus.data_out;
    v = bus.rd_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       v;
    logic [7:0] addrs [6];
    int         exps  [6];
    bit         seen  [256];

    bus.re = 1'b0;
    bus.address_read = 8'h00;

    exp_tab[0] = 0;
    exp_tab[1] = 1;
    for (int p = 2; p < 256; p++)
      exp_tab[p] = gf_mul(exp_tab[p-1], 2);
    log_tab[0] = 0;
    for (int p = 1; p < 256; p++)
      log_tab[exp_tab[p]] = p;

    check("model_log_1d", log_tab[8'h1D], 9);
    check("model_log_03", log_tab[8'h03], 26);
    check("model_log_8e", log_tab[8'h8E], 255);
    check("model_exp_2", exp_tab[2], 2);

    // plain build with re low
    do_reset();
    wait_ready();

    addrs = '{8'h00, 8'h01, 8'h02, 8'h1D, 8'h03, 8'h8E};
    exps  = '{0, 1, 2, 9, 26, 255};
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], d, v);
      check("dir_dout", 32'(d), exps[i]);
      check("dir_vld", 32'(v), 1);
    end

    rd(8'h8E, d, v);
    check("hold_dout1", 32'(d), 255);
    check("hold_vld1", 32'(v), 1);
    @(posedge clk);
    #1;
    check("hold_dout2", 32'(bus.data_out), 255);
    check("hold_vld2", 32'(bus.rd_valid), 0);

    for (int p = 1; p < 256; p++) begin
      rd(8'(exp_tab[p]), d, v);
      check("round_trip", 32'(d), p);
    end

    for (int a = 1; a < 256; a++) begin
      rd(8'(a), d, v);
      check("distinct", 32'(d != 0 && !seen[d]), 1);
      seen[d] = 1'b1;
    end

    // re held high from reset through the build
    bus.re = 1'b1;
    bus.address_read = 8'h02;
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk);
      #1;
      check("early_vld", 32'(bus.rd_valid), 0);
    end
    @(posedge clk);
    #1;
    check("first_vld", 32'(bus.rd_valid), 1);
    check("first_dout", 32'(bus.data_out), 2);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("b2b_vld", 32'(bus.rd_valid), 1);
      check("b2b_dout", 32'(bus.data_out), 2);
    end

    // reset while ready and streaming, then again mid-build
    do_reset();
    bus.re = 1'b0;
    repeat (99) @(posedge clk);
    do_reset();
    wait_ready();
    rd(8'h1D, d, v);
    check("rebuild_dout", 32'(d), 9);
    check("rebuild_vld", 32'(v), 1);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
